cla_pipe_adder: RTL

Parametrised, pipelined successor to the fixed 16-bit carry-lookahead adder. It adds or subtracts two WIDTH-bit operands with carry-in and returns a WIDTH+1-bit result {cout, sum} plus a signed-overflow flag. The carry chain is built from GROUP-bit lookahead groups and cut into STAGES register stages. Operands and results move through valid/ready handshakes with per-stage bubble collapse, so the block drops into streaming datapaths and approximate-computing evaluation benches.

---
 rtl/cla_pipe_adder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: each of STAGES register stages
// resolves WIDTH/STAGES result bits with GROUP-bit lookahead, valid/ready throughout.

module cla_stage #(
    parameter int S     = 8,
    parameter int GROUP = 4
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         cin,
    output logic [S-1:0] sum,
    output logic         cout
);
    localparam int NG = S / GROUP;

    logic [S-1:0]  g, p;
    logic [NG:0]   cg;
    logic [NG-1:0] gg, pg;

    always_comb begin : comb_cla
        logic c, t;
        g   = a & b;
        p   = a ^ b;
        gg  = '0;
        pg  = '0;
        cg  = '0;
        sum = '0;
        c   = 1'b0;
        t   = 1'b0;
        cg[0] = cin;
        // group generate/propagate, then lookahead across groups
        for (int j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            pg[j] = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
                pg[j] = pg[j] & p[j*GROUP+i];
            end
            cg[j+1] = gg[j] | (pg[j] & cg[j]);
        end
        // per-bit carries as flat sum-of-products inside each group
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                c = cg[j];
                for (int k = 0; k < i; k++) c = c & p[j*GROUP+k];
                for (int k = 0; k < i; k++) begin
                    t = g[j*GROUP+k];
                    for (int m = k + 1; m < i; m++) t = t & p[j*GROUP+m];
                    c = c | t;
                end
                sum[j*GROUP+i] = p[j*GROUP+i] ^ c;
            end
        end
        cout = cg[NG];
    end
endmodule

module cla_pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_ovf
);
    localparam int S = WIDTH / STAGES;
    localparam int L = STAGES - 1;

    generate
        if (GROUP < 1 || STAGES < 1 || STAGES > WIDTH / GROUP ||
            (WIDTH % (STAGES * GROUP)) != 0) begin : g_bad_params
            $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*GROUP and 1 <= STAGES <= WIDTH/GROUP");
        end
    endgenerate

    logic [STAGES-1:0]            v, vin;
    logic [STAGES:0]              go;
    logic [STAGES-1:0][WIDTH-1:0] st_a, st_b, st_s, nxt_s;
    logic [STAGES-1:0]            st_c;
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [STAGES-1:0]            c_q;
    logic [STAGES-1:0][S-1:0]     slice_sum;
    logic [STAGES-1:0]            slice_cout;
    logic                         nxt_o, o_q;

    // go[k]: stage k loads this cycle; go[STAGES] is the downstream accept
    always_comb begin
        go = '0;
        go[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) go[k] = !v[k] || go[k+1];
    end

    assign in_ready  = go[0];
    assign out_valid = v[L];
    assign out_sum   = {c_q[L], s_q[L]};
    assign out_ovf   = o_q;

    always_comb begin
        vin     = '0;
        st_a    = '0;
        st_b    = '0;
        st_s    = '0;
        st_c    = '0;
        vin[0]  = in_valid;
        st_a[0] = in_a;
        st_b[0] = in_b ^ {WIDTH{in_sub}};
        st_c[0] = in_cin;
        for (int k = 1; k < STAGES; k++) begin
            vin[k]  = v[k-1];
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_s[k] = s_q[k-1];
            st_c[k] = c_q[k-1];
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            cla_stage #(.S(S), .GROUP(GROUP)) u_stage (
                .a    (st_a[k][k*S +: S]),
                .b    (st_b[k][k*S +: S]),
                .cin  (st_c[k]),
                .sum  (slice_sum[k]),
                .cout (slice_cout[k])
            );
        end
    endgenerate

    always_comb begin
        nxt_s = st_s;
        for (int k = 0; k < STAGES; k++) nxt_s[k][k*S +: S] = slice_sum[k];
        nxt_o = (st_a[L][WIDTH-1] == st_b[L][WIDTH-1]) &&
                (nxt_s[L][WIDTH-1] != st_a[L][WIDTH-1]);
    end

    // data only moves with a valid beat, so a stalled output never changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v   <= '0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= '0;
            o_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (go[k]) begin
                    v[k] <= vin[k];
                    if (vin[k]) begin
                        a_q[k] <= st_a[k];
                        b_q[k] <= st_b[k];
                        s_q[k] <= nxt_s[k];
                        c_q[k] <= slice_cout[k];
                    end
                end
            end
            if (go[L] && vin[L]) o_q <= nxt_o;
        end
    end
endmodule
